// File: rtl/adder_serial_pipe.sv
// Digit-serial add/subtract unit: resolves one DIGIT-bit carry slice per clock,
// with valid/ready handshakes, carry-out (inverted borrow) and signed overflow.
module adder_serial_pipe #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_next_s;
  // a_r doubles as the sum accumulator: digits of A shift out the bottom
  // while result digits shift in at the top.
  logic [WIDTH-1:0]       a_r, b_r, a_next_s;
  logic [WIDTH+DIGIT-1:0] a_cat_s;
  logic                   c_r;
  logic [KW-1:0]          k_r;
  logic [DIGIT:0]         dsum_s;
  logic                   last_s, accept_s, ovf_s;

  assign dsum_s   = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
  assign a_cat_s  = {dsum_s[DIGIT-1:0], a_r};
  assign a_next_s = a_cat_s[WIDTH+DIGIT-1:DIGIT];
  assign last_s   = (k_r == K_LAST);
  assign accept_s = in_valid & in_ready;
  // Carry into the top bit is recovered from the operand and sum bits at that position.
  assign ovf_s    = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dsum_s[DIGIT-1] ^ dsum_s[DIGIT];

  // Input-side ready: free when idle, or when the held result is being taken.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = RUN;
      end
      DONE: begin
        if (accept_s)       state_next_s = RUN;
        else if (out_ready) state_next_s = IDLE;
        else                state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand/carry datapath and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      c_r       <= 1'b0;
      k_r       <= {KW{1'b0}};
      out_valid <= 1'b0;
      out_sum   <= {WIDTH{1'b0}};
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        a_r <= in_a;
        b_r <= in_sub ? ~in_b : in_b;
        c_r <= in_sub ? ~in_cin : in_cin;
        k_r <= {KW{1'b0}};
      end else if (state_r == RUN) begin
        a_r <= a_next_s;
        b_r <= b_r >> DIGIT;
        c_r <= dsum_s[DIGIT];
        k_r <= last_s ? {KW{1'b0}} : k_r + KW'(1);
      end
      if ((state_r == RUN) && last_s) begin
        out_sum   <= a_next_s;
        out_cout  <= dsum_s[DIGIT];
        out_ovf   <= ovf_s;
        out_valid <= 1'b1;
      end else if ((state_r == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_serial_pipe.sv
// Randomized self-checking bench for adder_serial_pipe: a 16/4 instance for
// latency, handshake and reset behaviour, and a 3/1 instance swept exhaustively.
module tb_adder_serial_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, icin16, isub16, ov16, or16, cout16, ovf16;
  logic [15:0] ia16, ib16, sum16;
  logic        iv3, ir3, icin3, isub3, ov3, or3, cout3, ovf3;
  logic [2:0]  ia3, ib3, sum3;

  adder_serial_pipe #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_a(ia16), .in_b(ib16),
    .in_cin(icin16), .in_sub(isub16), .out_valid(ov16), .out_ready(or16),
    .out_sum(sum16), .out_cout(cout16), .out_ovf(ovf16));

  adder_serial_pipe #(.WIDTH(3), .DIGIT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_a(ia3), .in_b(ib3),
    .in_cin(icin3), .in_sub(isub3), .out_valid(ov3), .out_ready(or3),
    .out_sum(sum3), .out_cout(cout3), .out_ovf(ovf3));

  int nchk = 0;
  int npass = 0;
  int e_sum16, e_cout16, e_ovf16;
  logic [15:0] edges [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_op(input int w, input int a, input int b, input int cin,
                                 input int sub, output int s, output int co, output int ovf);
    int m, h, r, sa, sb, sr;
    m = 1 << w;
    h = m / 2;
    if (sub == 0) begin
      r  = a + b + cin;
      co = (r >= m) ? 1 : 0;
    end else begin
      r  = a - b - cin;
      co = (a >= b + cin) ? 1 : 0;
    end
    s  = ((r % m) + m) % m;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    sr = (sub == 0) ? sa + sb + cin : sa - sb - cin;
    ovf = (sr < -h || sr >= h) ? 1 : 0;
  endfunction

  // Present operands and wait for the accept edge; operands are scrambled afterwards.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int n = 0;
    ia16 = a; ib16 = b; icin16 = cin; isub16 = sub; iv16 = 1'b1;
    ref_op(16, int'(a), int'(b), int'(cin), int'(sub), e_sum16, e_cout16, e_ovf16);
    while (!ir16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready16", 32'(ir16), 32'd1);
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    ia16 = 16'($urandom); ib16 = 16'($urandom);
    icin16 = 1'($urandom); isub16 = 1'($urandom);
  endtask

  // Wait for the result, check it, then hold it under backpressure for 'hold' cycles.
  task automatic recv16(input int hold);
    int lat = 0;
    while (!ov16 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("lat16", 32'(lat), 32'd4);
    check("sum16", 32'(sum16), 32'(e_sum16));
    check("cout16", 32'(cout16), 32'(e_cout16));
    check("ovf16", 32'(ovf16), 32'(e_ovf16));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid16", 32'(ov16), 32'd1);
      check("hold_ready16", 32'(ir16), 32'd0);
      check("hold_sum16", 32'(sum16), 32'(e_sum16));
    end
  endtask

  task automatic ack16();
    or16 = 1'b1;
    @(posedge clk);
    #1;
    check("ack_drop16", 32'(ov16), 32'd0);
    or16 = 1'b0;
  endtask

  task automatic op3(input int a, input int b, input int cin, input int sub);
    int n = 0;
    int s, co, ovf;
    ref_op(3, a, b, cin, sub, s, co, ovf);
    ia3 = 3'(a); ib3 = 3'(b); icin3 = 1'(cin); isub3 = 1'(sub); iv3 = 1'b1;
    while (!ir3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    iv3 = 1'b0;
    ia3 = 3'($urandom); ib3 = 3'($urandom);
    n = 0;
    while (!ov3 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("sum3 a%0d b%0d c%0d s%0d", a, b, cin, sub), 32'(sum3), 32'(s));
    check($sformatf("cout3 a%0d b%0d c%0d s%0d", a, b, cin, sub), 32'(cout3), 32'(co));
    check($sformatf("ovf3 a%0d b%0d c%0d s%0d", a, b, cin, sub), 32'(ovf3), 32'(ovf));
  endtask

  initial begin
    int cnt;
    logic [15:0] ra, rb;
    edges[0] = 16'h0000; edges[1] = 16'h0001; edges[2] = 16'h7FFF;
    edges[3] = 16'h8000; edges[4] = 16'hFFFF;
    rst_n = 1'b0;
    iv16 = 1'b0; ia16 = 16'h0000; ib16 = 16'h0000; icin16 = 1'b0; isub16 = 1'b0; or16 = 1'b0;
    iv3 = 1'b0; ia3 = 3'd0; ib3 = 3'd0; icin3 = 1'b0; isub3 = 1'b0; or3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ir16), 32'd1);
    check("rst_valid", 32'(ov16), 32'd0);
    check("rst_sum", 32'(sum16), 32'd0);
    check("rst_cout", 32'(cout16), 32'd0);
    check("rst_ovf", 32'(ovf16), 32'd0);
    rst_n = 1'b1;

    // Directed cases with known answers.
    send16(16'h1234, 16'h0FFF, 1'b1, 1'b0); recv16(0);
    check("dir_sum_1234", 32'(sum16), 32'h2234); ack16();
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0); recv16(0);
    check("dir_ovf_7fff", 32'(ovf16), 32'd1); ack16();
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0); recv16(0);
    check("dir_cout_ffff", 32'(cout16), 32'd1); ack16();
    send16(16'h0005, 16'h0007, 1'b0, 1'b1); recv16(0);
    check("dir_sub_fffe", 32'(sum16), 32'hFFFE); ack16();
    send16(16'h8000, 16'h0001, 1'b0, 1'b1); recv16(3);
    check("dir_sub_7fff", 32'(sum16), 32'h7FFF);

    // Back-to-back: release the held result and accept new operands the same edge.
    or16 = 1'b1;
    send16(16'h1111, 16'h2222, 1'b0, 1'b0);
    check("b2b_drop", 32'(ov16), 32'd0);
    or16 = 1'b0;
    recv16(1);
    ack16();

    // Reset while k==2: result must never appear.
    send16(16'h4321, 16'h0101, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_ready", 32'(ir16), 32'd1);
    check("midrst_valid", 32'(ov16), 32'd0);
    check("midrst_sum", 32'(sum16), 32'd0);
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ov16) cnt++;
    end
    check("midrst_no_stale", 32'(cnt), 32'd0);

    // Reset while a result is held under backpressure.
    send16(16'h00FF, 16'h0001, 1'b0, 1'b0); recv16(1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("vrst_valid", 32'(ov16), 32'd0);
    check("vrst_sum", 32'(sum16), 32'd0);

    // Randomized transactions with idle gaps and random backpressure.
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = edges[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) rb = edges[$urandom_range(0, 4)];
      send16(ra, rb, 1'($urandom), 1'($urandom));
      recv16($urandom_range(0, 2));
      ack16();
    end

    // Exhaustive 3-bit, bit-serial sweep in both modes.
    for (int sub = 0; sub < 2; sub++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          for (int c = 0; c < 2; c++)
            op3(a, b, c, sub);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
